// File: rtl/range_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : range_burst_scheduler
//  Description : Round-robin scheduler that shares one range-finder datapath
//                between NREQ sample-stream requesters. Forms go/finish
//                timing for each burst and returns range, requester ID and
//                sample count on a valid/ready result port.
//  Revision    : 1.0 - initial release
// ============================================================================
module range_burst_scheduler #(
    parameter int WIDTH = 8,
    parameter int NREQ  = 4,
    parameter int IDW   = $clog2(NREQ),
    parameter int CNTW  = 8
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req_valid,
    input  logic [NREQ*WIDTH-1:0] req_data,
    input  logic [NREQ-1:0]       req_last,
    output logic [NREQ-1:0]       req_ready,
    output logic [WIDTH-1:0]      rf_data,
    output logic                  rf_go,
    output logic                  rf_finish,
    input  logic [WIDTH-1:0]      rf_range,
    input  logic                  rf_error,
    output logic                  res_valid,
    input  logic                  res_ready,
    output logic [WIDTH-1:0]      res_range,
    output logic [IDW-1:0]        res_id,
    output logic [CNTW-1:0]       res_count,
    output logic                  res_error,
    output logic                  busy
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_FIRST  = 3'd1,
        S_ACTIVE = 3'd2,
        S_FINISH = 3'd3,
        S_RESULT = 3'd4
    } state_t;

    // One extra bit so rr + offset can be wrapped for non-power-of-two NREQ.
    localparam int SW = IDW + 1;

    state_t            state_q, state_d;
    logic [IDW-1:0]    rr_q, rr_d;
    logic [IDW-1:0]    gnt_q, gnt_d;
    logic [WIDTH-1:0]  hold_q, hold_d;
    logic [CNTW-1:0]   cnt_q, cnt_d;
    logic              err_seen_q, err_seen_d;
    logic [WIDTH-1:0]  res_range_q, res_range_d;
    logic [IDW-1:0]    res_id_q, res_id_d;
    logic [CNTW-1:0]   res_count_q, res_count_d;
    logic              res_error_q, res_error_d;

    logic [WIDTH-1:0]  w_data_arr [NREQ];
    logic [WIDTH-1:0]  w_gdata;
    logic              w_in_burst;
    logic              w_acc;
    logic              w_any;
    logic [IDW-1:0]    w_pick;
    logic [SW-1:0]     w_sum;

    generate
        for (genvar i = 0; i < NREQ; i++) begin : g_unpack
            assign w_data_arr[i] = req_data[i*WIDTH +: WIDTH];
        end
    endgenerate

    assign w_gdata    = w_data_arr[gnt_q];
    assign w_in_burst = (state_q == S_FIRST) || (state_q == S_ACTIVE);
    assign w_acc      = w_in_burst && req_valid[gnt_q];

    // Round-robin search: first valid requester at or after the rr pointer.
    always_comb begin
        w_any  = 1'b0;
        w_pick = '0;
        w_sum  = '0;
        for (int k = 0; k < NREQ; k++) begin
            w_sum = SW'(rr_q) + SW'(k);
            if (w_sum >= SW'(NREQ)) begin
                w_sum = w_sum - SW'(NREQ);
            end
            if (!w_any && req_valid[w_sum[IDW-1:0]]) begin
                w_any  = 1'b1;
                w_pick = w_sum[IDW-1:0];
            end
        end
    end

    // State and datapath registers; reset abandons any burst in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            rr_q        <= '0;
            gnt_q       <= '0;
            hold_q      <= '0;
            cnt_q       <= '0;
            err_seen_q  <= 1'b0;
            res_range_q <= '0;
            res_id_q    <= '0;
            res_count_q <= '0;
            res_error_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            rr_q        <= rr_d;
            gnt_q       <= gnt_d;
            hold_q      <= hold_d;
            cnt_q       <= cnt_d;
            err_seen_q  <= err_seen_d;
            res_range_q <= res_range_d;
            res_id_q    <= res_id_d;
            res_count_q <= res_count_d;
            res_error_q <= res_error_d;
        end
    end

    // Next-state logic: grant, burst feed, result capture, result handoff.
    always_comb begin
        state_d     = state_q;
        rr_d        = rr_q;
        gnt_d       = gnt_q;
        hold_d      = hold_q;
        cnt_d       = cnt_q;
        err_seen_d  = err_seen_q;
        res_range_d = res_range_q;
        res_id_d    = res_id_q;
        res_count_d = res_count_q;
        res_error_d = res_error_q;
        case (state_q)
            S_IDLE: begin
                if (w_any) begin
                    gnt_d      = w_pick;
                    err_seen_d = 1'b0;
                    state_d    = S_FIRST;
                end
            end
            S_FIRST: begin
                if (rf_error) begin
                    err_seen_d = 1'b1;
                end
                if (w_acc) begin
                    hold_d  = w_gdata;
                    cnt_d   = CNTW'(1);
                    state_d = req_last[gnt_q] ? S_FINISH : S_ACTIVE;
                end
            end
            S_ACTIVE: begin
                if (rf_error) begin
                    err_seen_d = 1'b1;
                end
                if (w_acc) begin
                    hold_d = w_gdata;
                    if (cnt_q != '1) begin
                        cnt_d = cnt_q + CNTW'(1);
                    end
                    if (req_last[gnt_q]) begin
                        state_d = S_FINISH;
                    end
                end
            end
            S_FINISH: begin
                res_range_d = rf_range;
                res_error_d = rf_error | err_seen_q;
                res_id_d    = gnt_q;
                res_count_d = cnt_q;
                rr_d        = (gnt_q == IDW'(NREQ - 1)) ? '0 : gnt_q + IDW'(1);
                state_d     = S_RESULT;
            end
            S_RESULT: begin
                if (res_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Outputs: one-hot ready to the granted requester, go only on first accept.
    always_comb begin
        req_ready = '0;
        if (w_in_burst) begin
            req_ready[gnt_q] = 1'b1;
        end
        rf_go     = (state_q == S_FIRST) && w_acc;
        rf_finish = (state_q == S_FINISH);
        rf_data   = w_acc ? w_gdata : hold_q;
        res_valid = (state_q == S_RESULT);
        busy      = (state_q != S_IDLE);
    end

    assign res_range = res_range_q;
    assign res_id    = res_id_q;
    assign res_count = res_count_q;
    assign res_error = res_error_q;

endmodule
`default_nettype wire

// File: tb/tb_range_burst_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : tb_range_burst_scheduler
//  Description : Directed self-checking bench for range_burst_scheduler with
//                a behavioural min/max range-finder model on the rf_* port.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_range_burst_scheduler;

    localparam int WIDTH = 8;
    localparam int NREQ  = 4;
    localparam int IDW   = 2;
    localparam int CNTW  = 8;

    logic                  clock = 1'b0;
    logic                  reset;
    logic [NREQ-1:0]       req_valid;
    logic [NREQ*WIDTH-1:0] req_data;
    logic [NREQ-1:0]       req_last;
    logic [NREQ-1:0]       req_ready;
    logic [WIDTH-1:0]      rf_data;
    logic                  rf_go;
    logic                  rf_finish;
    logic [WIDTH-1:0]      rf_range;
    logic                  rf_error;
    logic                  res_valid;
    logic                  res_ready;
    logic [WIDTH-1:0]      res_range;
    logic [IDW-1:0]        res_id;
    logic [CNTW-1:0]       res_count;
    logic                  res_error;
    logic                  busy;

    int n_checks = 0;
    int n_errors = 0;

    range_burst_scheduler #(
        .WIDTH (WIDTH),
        .NREQ  (NREQ),
        .IDW   (IDW),
        .CNTW  (CNTW)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rf_data   (rf_data),
        .rf_go     (rf_go),
        .rf_finish (rf_finish),
        .rf_range  (rf_range),
        .rf_error  (rf_error),
        .res_valid (res_valid),
        .res_ready (res_ready),
        .res_range (res_range),
        .res_id    (res_id),
        .res_count (res_count),
        .res_error (res_error),
        .busy      (busy)
    );

    always #5 clock = ~clock;

    // Range-finder model: go restarts min/max, every other cycle folds data in.
    logic [WIDTH-1:0] mn, mx;
    always @(posedge clock) begin
        if (rf_go) begin
            mn <= rf_data;
            mx <= rf_data;
        end else begin
            if (rf_data < mn) mn <= rf_data;
            if (rf_data > mx) mx <= rf_data;
        end
    end
    assign rf_range = mx - mn;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic settle();
        #3;
    endtask

    task automatic set_req(input int id, input logic v, input logic [7:0] d, input logic l);
        req_valid[id]          = v;
        req_data[id*WIDTH +: WIDTH] = d;
        req_last[id]           = l;
    endtask

    task automatic clr_all();
        req_valid = '0;
        req_data  = '0;
        req_last  = '0;
    endtask

    task automatic check_zero(input string tag);
        check({tag, "_ready"},  32'(req_ready), 32'h0);
        check({tag, "_go"},     32'(rf_go),     32'h0);
        check({tag, "_finish"}, 32'(rf_finish), 32'h0);
        check({tag, "_data"},   32'(rf_data),   32'h0);
        check({tag, "_rvalid"}, 32'(res_valid), 32'h0);
        check({tag, "_rrange"}, 32'(res_range), 32'h0);
        check({tag, "_rid"},    32'(res_id),    32'h0);
        check({tag, "_rcount"}, 32'(res_count), 32'h0);
        check({tag, "_rerror"}, 32'(res_error), 32'h0);
        check({tag, "_busy"},   32'(busy),      32'h0);
    endtask

    // Two-sample burst from requester g while requester o waits with valid high.
    task automatic two_burst(input int g, input int o, input logic [7:0] a, input logic [7:0] b);
        logic [7:0] rng;
        rng = (a > b) ? a - b : b - a;
        set_req(o, 1'b1, 8'd99, 1'b1);
        set_req(g, 1'b1, a, 1'b0);
        settle();
        check("rr_idle_ready", 32'(req_ready), 32'h0);
        step(); settle();
        check("rr_first_ready", 32'(req_ready), 32'(1 << g));
        check("rr_first_go",    32'(rf_go),     32'h1);
        check("rr_first_data",  32'(rf_data),   32'(a));
        step();
        set_req(g, 1'b1, b, 1'b1);
        settle();
        check("rr_last_ready", 32'(req_ready), 32'(1 << g));
        check("rr_last_data",  32'(rf_data),   32'(b));
        step();
        set_req(g, 1'b1, a, 1'b0);
        settle();
        check("rr_fin_ready",  32'(req_ready), 32'h0);
        check("rr_fin_finish", 32'(rf_finish), 32'h1);
        step(); settle();
        check("rr_res_valid", 32'(res_valid), 32'h1);
        check("rr_res_id",    32'(res_id),    32'(g));
        check("rr_res_range", 32'(res_range), 32'(rng));
        check("rr_res_count", 32'(res_count), 32'd2);
        step();
    endtask

    initial begin
        reset     = 1'b1;
        res_ready = 1'b1;
        rf_error  = 1'b0;
        clr_all();
        #3;
        check_zero("por");
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // ---- Req0 burst 5,20,3,17 back to back ----
        set_req(0, 1'b1, 8'd5, 1'b0);
        settle();
        check("t1_idle_ready", 32'(req_ready), 32'h0);
        check("t1_idle_go",    32'(rf_go),     32'h0);
        check("t1_idle_busy",  32'(busy),      32'h0);
        step(); settle();
        check("t1_first_ready", 32'(req_ready), 32'h1);
        check("t1_first_go",    32'(rf_go),     32'h1);
        check("t1_first_data",  32'(rf_data),   32'd5);
        check("t1_first_busy",  32'(busy),      32'h1);
        step(); set_req(0, 1'b1, 8'd20, 1'b0); settle();
        check("t1_s2_go",   32'(rf_go),   32'h0);
        check("t1_s2_data", 32'(rf_data), 32'd20);
        step(); set_req(0, 1'b1, 8'd3, 1'b0); settle();
        check("t1_s3_data", 32'(rf_data), 32'd3);
        step(); set_req(0, 1'b1, 8'd17, 1'b1); settle();
        check("t1_s4_data",   32'(rf_data),   32'd17);
        check("t1_s4_finish", 32'(rf_finish), 32'h0);
        step(); clr_all(); settle();
        check("t1_fin_finish", 32'(rf_finish), 32'h1);
        check("t1_fin_go",     32'(rf_go),     32'h0);
        check("t1_fin_ready",  32'(req_ready), 32'h0);
        check("t1_fin_data",   32'(rf_data),   32'd17);
        check("t1_fin_rvalid", 32'(res_valid), 32'h0);
        step(); settle();
        check("t1_res_valid", 32'(res_valid), 32'h1);
        check("t1_res_range", 32'(res_range), 32'd17);
        check("t1_res_id",    32'(res_id),    32'd0);
        check("t1_res_count", 32'(res_count), 32'd4);
        check("t1_res_error", 32'(res_error), 32'h0);
        check("t1_res_fin",   32'(rf_finish), 32'h0);
        step(); settle();
        check("t1_done_valid", 32'(res_valid), 32'h0);
        check("t1_done_busy",  32'(busy),      32'h0);

        // ---- Req2 single sample 42 ----
        set_req(2, 1'b1, 8'd42, 1'b1);
        settle();
        step(); settle();
        check("t2_first_ready", 32'(req_ready), 32'h4);
        check("t2_first_go",    32'(rf_go),     32'h1);
        check("t2_first_data",  32'(rf_data),   32'd42);
        check("t2_first_fin",   32'(rf_finish), 32'h0);
        step(); clr_all(); settle();
        check("t2_fin_finish", 32'(rf_finish), 32'h1);
        check("t2_fin_go",     32'(rf_go),     32'h0);
        step(); settle();
        check("t2_res_valid", 32'(res_valid), 32'h1);
        check("t2_res_range", 32'(res_range), 32'd0);
        check("t2_res_id",    32'(res_id),    32'd2);
        check("t2_res_count", 32'(res_count), 32'd1);
        check("t2_res_error", 32'(res_error), 32'h0);
        step();

        // ---- Req1 burst 10, three bubbles, 200 ----
        set_req(1, 1'b1, 8'd10, 1'b0);
        settle();
        step(); settle();
        check("t3_first_ready", 32'(req_ready), 32'h2);
        check("t3_first_data",  32'(rf_data),   32'd10);
        for (int i = 0; i < 3; i++) begin
            step();
            clr_all();
            if (i == 1) req_last[1] = 1'b1;
            settle();
            check("t3_bub_data",   32'(rf_data),   32'd10);
            check("t3_bub_ready",  32'(req_ready), 32'h2);
            check("t3_bub_finish", 32'(rf_finish), 32'h0);
        end
        step(); set_req(1, 1'b1, 8'd200, 1'b1); settle();
        check("t3_last_data", 32'(rf_data), 32'd200);
        step(); clr_all(); settle();
        check("t3_fin_finish", 32'(rf_finish), 32'h1);
        step(); settle();
        check("t3_res_range", 32'(res_range), 32'd190);
        check("t3_res_count", 32'(res_count), 32'd2);
        check("t3_res_id",    32'(res_id),    32'd1);
        step();

        // ---- Req0 and req2 contending from reset ----
        clr_all();
        reset = 1'b1;
        #1;
        check_zero("t4_rst");
        step();
        reset = 1'b0;
        two_burst(0, 2, 8'd8,  8'd30);
        two_burst(2, 0, 8'd50, 8'd45);
        two_burst(0, 2, 8'd1,  8'd255);
        two_burst(2, 0, 8'd7,  8'd7);
        clr_all();

        // ---- Result backpressure with req1 pending, error flag on req3 ----
        res_ready = 1'b0;
        set_req(3, 1'b1, 8'd77, 1'b1);
        set_req(1, 1'b1, 8'd60, 1'b1);
        settle();
        step(); settle();
        check("t5_first_ready", 32'(req_ready), 32'h8);
        rf_error = 1'b1;
        step();
        rf_error = 1'b0;
        set_req(3, 1'b0, 8'd0, 1'b0);
        settle();
        check("t5_fin_finish", 32'(rf_finish), 32'h1);
        for (int i = 0; i < 5; i++) begin
            step(); settle();
            check("t5_hold_valid", 32'(res_valid), 32'h1);
            check("t5_hold_id",    32'(res_id),    32'd3);
            check("t5_hold_range", 32'(res_range), 32'd0);
            check("t5_hold_count", 32'(res_count), 32'd1);
            check("t5_hold_error", 32'(res_error), 32'h1);
            check("t5_hold_ready", 32'(req_ready), 32'h0);
        end
        res_ready = 1'b1;
        #1;
        check("t5_acc_valid", 32'(res_valid), 32'h1);
        step(); settle();
        check("t5_idle_valid", 32'(res_valid), 32'h0);
        check("t5_idle_ready", 32'(req_ready), 32'h0);
        step(); settle();
        check("t5_grant_ready", 32'(req_ready), 32'h2);
        check("t5_grant_go",    32'(rf_go),     32'h1);
        check("t5_grant_data",  32'(rf_data),   32'd60);
        step(); clr_all(); settle();
        step(); settle();
        check("t5_res1_id",    32'(res_id),    32'd1);
        check("t5_res1_error", 32'(res_error), 32'h0);
        step();

        // ---- Reset in the middle of a req3 burst ----
        set_req(3, 1'b1, 8'd11, 1'b0);
        settle();
        step(); settle();
        check("t6_first_ready", 32'(req_ready), 32'h8);
        step(); set_req(3, 1'b1, 8'd22, 1'b0); settle();
        check("t6_s2_data", 32'(rf_data), 32'd22);
        step(); set_req(3, 1'b1, 8'd33, 1'b0); settle();
        reset = 1'b1;
        #1;
        check_zero("t6_rst");
        step(); step();
        reset = 1'b0;
        set_req(1, 1'b1, 8'd9, 1'b1);
        settle();
        check("t6_idle_valid", 32'(res_valid), 32'h0);
        check("t6_idle_busy",  32'(busy),      32'h0);
        step(); settle();
        check("t6_grant_ready", 32'(req_ready), 32'h2);
        step(); clr_all(); settle();
        check("t6_fin_finish", 32'(rf_finish), 32'h1);
        step(); settle();
        check("t6_res_valid", 32'(res_valid), 32'h1);
        check("t6_res_id",    32'(res_id),    32'd1);
        check("t6_res_count", 32'(res_count), 32'd1);
        check("t6_res_range", 32'(res_range), 32'd0);
        step(); settle();
        check("t6_done_valid", 32'(res_valid), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
